// File: rtl/rsa_sequencer.sv
// Sequences RSA core Main through key generation, stage 1 and encryption for one request at a time.
// Latency: accept to rsp_valid = 2 + blank/finish + GAP + 1 + S1_WAIT + GAP + 1 + blank/fin1 + 1 cycles.
// Backpressure: req_ready only in IDLE; the response holds stable until rsp_valid&rsp_ready.
module rsa_sequencer #(
  parameter int TIMEOUT = 4096,
  parameter int GAP     = 4,
  parameter int S1_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_M,
  input  logic [7:0]  req_p,
  input  logic [7:0]  req_q,
  output logic [15:0] M,
  output logic [7:0]  p,
  output logic [7:0]  q,
  output logic        start,
  output logic        start1,
  output logic        start2,
  input  logic        finish,
  input  logic        fin1,
  input  logic [7:0]  e,
  input  logic [15:0] n,
  input  logic [15:0] d,
  input  logic [15:0] remainder,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_e,
  output logic [15:0] rsp_n,
  output logic [15:0] rsp_d,
  output logic [15:0] rsp_c,
  output logic [1:0]  rsp_err,
  output logic        busy
);

  localparam int MAXC = (TIMEOUT > GAP) ? ((TIMEOUT > S1_WAIT) ? TIMEOUT : S1_WAIT)
                                        : ((GAP > S1_WAIT) ? GAP : S1_WAIT);
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
  localparam logic [CW-1:0] S1_LAST  = CW'(S1_WAIT - 1);

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_ARGS = 2'd1;
  localparam logic [1:0] ERR_TO   = 2'd2;
  localparam logic [1:0] ERR_MGEN = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CHECK, ST_S0_GO, ST_S0_WAIT, ST_GAP0, ST_S1_GO,
    ST_S1_WAIT, ST_GAP1, ST_S2_GO, ST_S2_WAIT, ST_RESP
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    err_nxt;
  logic          accept;
  logic          cap_key;
  logic          cap_c;
  logic          counting;

  // Phase 0 and 1 exits skip the gap state entirely when GAP is zero.
  localparam state_t AFTER_S0 = (GAP == 0) ? ST_S1_GO : ST_GAP0;
  localparam state_t AFTER_S1 = (GAP == 0) ? ST_S2_GO : ST_GAP1;

  assign accept   = (state == ST_IDLE) && req_ready && req_valid;
  assign counting = (state == ST_S0_WAIT) || (state == ST_GAP0) || (state == ST_S1_WAIT) ||
                    (state == ST_GAP1) || (state == ST_S2_WAIT);

  // Next-state, result code and capture strobes; first wait cycle ignores stale done levels.
  always_comb begin
    nxt     = state;
    err_nxt = rsp_err;
    cap_key = 1'b0;
    cap_c   = 1'b0;
    case (state)
      ST_IDLE:    if (accept) nxt = ST_CHECK;
      ST_CHECK: begin
        if ((p < 8'd2) || (q < 8'd2) || (p == q)) begin
          nxt     = ST_RESP;
          err_nxt = ERR_ARGS;
        end else begin
          nxt = ST_S0_GO;
        end
      end
      ST_S0_GO:   nxt = ST_S0_WAIT;
      ST_S0_WAIT: begin
        if ((cnt != '0) && finish) begin
          cap_key = 1'b1;
          if (M >= n) begin
            nxt     = ST_RESP;
            err_nxt = ERR_MGEN;
          end else begin
            nxt = AFTER_S0;
          end
        end else if (cnt == TO_LAST) begin
          nxt     = ST_RESP;
          err_nxt = ERR_TO;
        end
      end
      ST_GAP0:    if (cnt == GAP_LAST) nxt = ST_S1_GO;
      ST_S1_GO:   nxt = ST_S1_WAIT;
      ST_S1_WAIT: if (cnt == S1_LAST) nxt = AFTER_S1;
      ST_GAP1:    if (cnt == GAP_LAST) nxt = ST_S2_GO;
      ST_S2_GO:   nxt = ST_S2_WAIT;
      ST_S2_WAIT: begin
        if ((cnt != '0) && fin1) begin
          cap_c   = 1'b1;
          nxt     = ST_RESP;
          err_nxt = ERR_OK;
        end else if (cnt == TO_LAST) begin
          nxt     = ST_RESP;
          err_nxt = ERR_TO;
        end
      end
      ST_RESP:    if (rsp_valid && rsp_ready) nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // Control outputs registered from next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      start     <= 1'b0;
      start1    <= 1'b0;
      start2    <= 1'b0;
    end else begin
      req_ready <= (nxt == ST_IDLE);
      busy      <= (nxt != ST_IDLE);
      rsp_valid <= (nxt == ST_RESP);
      start     <= (nxt == ST_S0_GO);
      start1    <= (nxt == ST_S1_GO);
      start2    <= (nxt == ST_S2_GO);
    end
  end

  // Shared dwell counter: restarts on every state change, advances only in timed states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (nxt != state)  cnt <= '0;
    else if (counting)      cnt <= cnt + CW'(1);
  end

  // Operand latch on accept, result capture as each phase completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      M       <= '0;
      p       <= '0;
      q       <= '0;
      rsp_e   <= '0;
      rsp_n   <= '0;
      rsp_d   <= '0;
      rsp_c   <= '0;
      rsp_err <= '0;
    end else if (accept) begin
      M       <= req_M;
      p       <= req_p;
      q       <= req_q;
      rsp_e   <= '0;
      rsp_n   <= '0;
      rsp_d   <= '0;
      rsp_c   <= '0;
      rsp_err <= '0;
    end else begin
      rsp_err <= err_nxt;
      if (cap_key) begin
        rsp_e <= e;
        rsp_n <= n;
        rsp_d <= d;
      end
      if (cap_c) rsp_c <= remainder;
    end
  end

endmodule

// File: tb/tb_rsa_sequencer.sv
// Scoreboard bench for rsa_sequencer with a behavioural Main model.
// Stimulus pushes expected responses; a negedge monitor pops and compares on each handshake.
// Expected values are hand-computed for p=67, q=53 (n=3551, phi=3432, e=5, d=1373).
module tb_rsa_sequencer;
  localparam int TIMEOUT = 4096;
  localparam int GAP     = 4;
  localparam int S1W     = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_M = '0;
  logic [7:0]  req_p = '0;
  logic [7:0]  req_q = '0;
  logic [15:0] M;
  logic [7:0]  p, q;
  logic        start, start1, start2;
  logic        finish = 1'b0;
  logic        fin1 = 1'b0;
  logic [7:0]  e = 8'd5;
  logic [15:0] n = '0;
  logic [15:0] d = 16'd1373;
  logic [15:0] remainder = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_e;
  logic [15:0] rsp_n, rsp_d, rsp_c;
  logic [1:0]  rsp_err;
  logic        busy;

  rsa_sequencer #(.TIMEOUT(TIMEOUT), .GAP(GAP), .S1_WAIT(S1W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_M(req_M), .req_p(req_p), .req_q(req_q),
    .M(M), .p(p), .q(q),
    .start(start), .start1(start1), .start2(start2),
    .finish(finish), .fin1(fin1),
    .e(e), .n(n), .d(d), .remainder(remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_e(rsp_e), .rsp_n(rsp_n), .rsp_d(rsp_d), .rsp_c(rsp_c),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  e;
    logic [15:0] n, d, c;
    logic [1:0]  err;
    int          lat;
    int          np0, np1, np2;
    int          acc;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input logic [7:0] ee, input logic [15:0] nn, input logic [15:0] dd,
                              input logic [15:0] cc, input logic [1:0] er, input int lat,
                              input int a, input int b, input int c);
    exp_t x;
    x.e = ee; x.n = nn; x.d = dd; x.c = cc; x.err = er; x.lat = lat;
    x.np0 = a; x.np1 = b; x.np2 = c; x.acc = 0;
    return x;
  endfunction

  function automatic logic [15:0] modexp(input logic [15:0] b, input logic [7:0] x, input logic [15:0] m);
    logic [31:0] r, bb;
    if (m == 16'd0) return 16'd0;
    r  = 32'd1;
    bb = {16'd0, b} % {16'd0, m};
    for (int i = 0; i < 8; i++) begin
      if (x[i]) r = (r * bb) % {16'd0, m};
      bb = (bb * bb) % {16'd0, m};
    end
    return r[15:0];
  endfunction

  // Main model: finish 5 cycles after start, fin1 6 after start2; both levels drop 2 cycles
  // after their start, so the first wait cycle always sees the previous run's stale level.
  int s0_at = -1000;
  int s2_at = -1000;
  bit fin1_kill = 1'b0;
  always @(negedge clk) begin
    n = {8'd0, p} * {8'd0, q};
    if (start) s0_at = cyc;
    if (start2) begin
      s2_at = cyc;
      remainder = modexp(M, e, n);
    end
    if (cyc - s0_at == 2) finish = 1'b0;
    if (cyc - s0_at == 5) finish = 1'b1;
    if (fin1_kill || (cyc - s2_at == 2)) fin1 = 1'b0;
    else if (cyc - s2_at == 6) fin1 = 1'b1;
  end

  // Monitor: pulse bookkeeping per request, response compare on handshake.
  int c0, c1, c2, t0, t1, t2;
  bit viol, ps0, ps1, ps2, rv_prev;
  int rv_cyc = 0;
  int hs_cyc = -1;
  int last_acc = 0;
  exp_t mx;
  always @(negedge clk) begin
    if (rst) begin
      c0 = 0; c1 = 0; c2 = 0; viol = 1'b0;
      ps0 = 1'b0; ps1 = 1'b0; ps2 = 1'b0; rv_prev = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        c0 = 0; c1 = 0; c2 = 0; viol = 1'b0;
      end
      if (start)  begin c0++; t0 = cyc; end
      if (start1) begin c1++; t1 = cyc; end
      if (start2) begin c2++; t2 = cyc; end
      if (int'(start) + int'(start1) + int'(start2) > 1) viol = 1'b1;
      if ((start && ps0) || (start1 && ps1) || (start2 && ps2)) viol = 1'b1;
      ps0 = start; ps1 = start1; ps2 = start2;
      if (rsp_valid && !rv_prev) rv_cyc = cyc;
      rv_prev = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        hs_cyc = cyc;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got response err=%0d, required no response", rsp_err);
        end else begin
          mx = sb.pop_front();
          check("rsp_e", rsp_e, mx.e);
          check("rsp_n", rsp_n, mx.n);
          check("rsp_d", rsp_d, mx.d);
          check("rsp_c", rsp_c, mx.c);
          check("rsp_err", rsp_err, mx.err);
          check("latency", rv_cyc - mx.acc, mx.lat);
          check("start_pulses", c0, mx.np0);
          check("start1_pulses", c1, mx.np1);
          check("start2_pulses", c2, mx.np2);
          check("pulse_overlap_or_stretch", viol, 0);
          if (mx.np1 == 1) check("gap_start_to_start1", (t1 - t0 - 1 >= GAP), 1);
          if (mx.np2 == 1) check("gap_start1_to_start2", (t2 - t1 - 1 >= GAP), 1);
          if (mx.err == 2'd0) check("e_times_d_mod_phi", (32'(rsp_e) * 32'(rsp_d)) % 3432, 1);
        end
      end
    end
  end

  task automatic send(input logic [15:0] m, input logic [7:0] pp, input logic [7:0] qq, input exp_t x);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_M = m; req_p = pp; req_q = qq;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        x.acc = cyc;
        last_acc = cyc;
        sb.push_back(x);
      end
    end
    check("req_accepted", ok, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check("rsp_arrived", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic stall20();
    bit got, bad;
    logic [57:0] snap;
    got = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check("stall_rsp_seen", got, 1);
    snap = {rsp_e, rsp_n, rsp_d, rsp_c, rsp_err};
    repeat (20) begin
      @(negedge clk);
      if ({rsp_e, rsp_n, rsp_d, rsp_c, rsp_err} !== snap || req_ready !== 1'b0 || rsp_valid !== 1'b1)
        bad = 1'b1;
    end
    check("stall_stable", bad, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
  endtask

  function automatic logic all_out_or();
    return |{req_ready, M, p, q, start, start1, start2, rsp_valid,
             rsp_e, rsp_n, rsp_d, rsp_c, rsp_err, busy};
  endfunction

  initial begin
    exp_t nom, bad;
    bit seen;
    nom = mk(8'd5, 16'd3551, 16'd1373, 16'd3156, 2'd0, 32, 1, 1, 1);
    bad = mk(8'd0, 16'd0, 16'd0, 16'd0, 2'd1, 2, 0, 0, 0);

    // Reset state
    #2 rst = 1'b1;
    #1 check("reset_outputs_zero", all_out_or(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("req_ready_after_reset", req_ready, 1);
    check("busy_idle", busy, 0);

    // Nominal run
    send(16'd1256, 8'd67, 8'd53, nom);
    drain(200);

    // Bad arguments
    send(16'd1256, 8'd53, 8'd53, bad);
    drain(50);
    send(16'd1256, 8'd1, 8'd7, bad);
    drain(50);

    // M >= n, with finish still high from the previous run
    send(16'd4000, 8'd67, 8'd53, mk(8'd5, 16'd3551, 16'd1373, 16'd0, 2'd3, 8, 1, 0, 0));
    drain(200);

    // Timeout in S2_WAIT
    fin1_kill = 1'b1;
    send(16'd1256, 8'd67, 8'd53, mk(8'd5, 16'd3551, 16'd1373, 16'd0, 2'd2, 26 + TIMEOUT, 1, 1, 1));
    drain(TIMEOUT + 400);
    fin1_kill = 1'b0;

    // Backpressure and back-to-back requests
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(16'd1256, 8'd67, 8'd53, nom);
    fork
      stall20();
      begin
        repeat (5) @(posedge clk);
        send(16'd1256, 8'd67, 8'd53, nom);
      end
    join
    check("b2b_accept_first_idle", last_acc - hs_cyc, 1);
    drain(200);

    // Reset during S1_WAIT
    send(16'd1256, 8'd67, 8'd53, nom);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (start1) seen = 1'b1;
    end
    check("start1_before_reset", seen, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("midrun_reset_outputs_zero", all_out_or(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_rsp_after_abort", rsp_valid, 0);
    send(16'd1256, 8'd67, 8'd53, nom);
    drain(200);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule

// File: doc/rsa_sequencer.md
Name: rsa_sequencer

Overview:
- Sequences the three-phase RSA core `Main` for one request at a time: key generation, stage-1 and encryption.
- Accepts a request (M, p, q) on a valid/ready handshake and drives Main's operand inputs and its start, start1 and start2 pulses.
- Waits on Main's finish and fin1 flags, then returns e, n, d and the ciphertext (remainder) on a valid/ready response port with an error code.
- Sits between the host/UART command layer and Main; replaces hand-timed start pulses.

Parameters:
- TIMEOUT, 4096: maximum cycles spent in any wait state before aborting with the timeout error.
- GAP, 4: idle cycles inserted between the end of one phase and the next start pulse.
- S1_WAIT, 8: fixed cycles allowed for the start1 phase, which has no completion flag.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request (IDLE only).
- req_M  in  16  plaintext.
- req_p  in  8  prime p.
- req_q  in  8  prime q.
- M  out  16  to Main; latched copy of req_M.
- p  out  8  to Main; latched copy of req_p.
- q  out  8  to Main; latched copy of req_q.
- start  out  1  one-cycle pulse that starts key generation.
- start1  out  1  one-cycle pulse that starts stage 1.
- start2  out  1  one-cycle pulse that starts encryption.
- finish  in  1  from Main; key generation done (level).
- fin1  in  1  from Main; encryption done (level).
- e  in  8  from Main.
- n  in  16  from Main.
- d  in  16  from Main.
- remainder  in  16  from Main.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_e  out  8  captured e.
- rsp_n  out  16  captured n.
- rsp_d  out  16  captured d.
- rsp_c  out  16  captured ciphertext.
- rsp_err  out  2  result code: 0 ok, 1 bad args, 2 timeout, 3 M>=n.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - Every output is 0 and the state is IDLE.
  - Reset asserted mid-operation aborts immediately: start pulses drop, no response is produced, and the in-flight request is lost.
- States: IDLE, CHECK, S0_GO, S0_WAIT, GAP0, S1_GO, S1_WAIT, GAP1, S2_GO, S2_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A handshake in cycle T latches req_M, req_p and req_q into M, p and q, and moves to CHECK.
  - M, p and q then stay stable until the next accepted request.
- CHECK (T+1):
  - If p<2, q<2 or p==q: go to RESP with err=1. No start pulses are issued and the rsp data fields are 0.
  - Otherwise go to S0_GO.
- S0_GO: start=1 for exactly one cycle, then S0_WAIT.
- S0_WAIT:
  - finish is ignored in the first cycle of the state, which blanks any stale level from a previous run.
  - From the second cycle on, finish==1 captures e, n and d, then:
    - if M >= n (16-bit unsigned compare against the live n): go to RESP with err=3;
    - otherwise go to GAP0.
- GAP0 and GAP1: each holds exactly GAP cycles. GAP=0 means a direct transition.
- S1_GO: start1=1 for one cycle.
- S1_WAIT: holds exactly S1_WAIT cycles, then GAP1.
- S2_GO: start2=1 for one cycle.
- S2_WAIT:
  - Same one-cycle blanking rule as S0_WAIT.
  - fin1==1 captures remainder into rsp_c and goes to RESP with err=0.
- Timeout:
  - A wait counter clears on entry to S0_WAIT or S2_WAIT and increments every cycle in that state.
  - If it reaches TIMEOUT-1 without the done flag: go to RESP with err=2.
  - Fields already captured keep their values; the rest are 0.
- Start pulses:
  - Registered outputs.
  - At most one of start, start1 and start2 is high in any cycle.
  - Each is never high for more than one consecutive cycle.
- RESP:
  - rsp_valid=1, with all rsp_* fields stable, until rsp_valid&rsp_ready.
  - Then IDLE on the next cycle; req_ready rises that cycle.
  - A req_valid present during RESP is not accepted until IDLE.
- rsp_* fields clear to 0 when a new request is accepted.
- finish and fin1 are sampled as levels; their deassertion timing is not checked.
- Nominal latency, accept to rsp_valid: 1 + 1 + (blank + finish latency) + GAP + 1 + S1_WAIT + GAP + 1 + (blank + fin1 latency) + 1 cycles.

Test Plan:
- Nominal run:
  - Stimulus: req M=1256, p=67, q=53, rsp_ready=1; Main model gives finish 5 cycles after start and fin1 6 cycles after start2.
  - Required: start, start1 and start2 each pulse exactly once, in order, separated by ≥GAP idle cycles.
  - Required: rsp_n=3551, rsp_err=0, rsp_c == 1256^rsp_e mod 3551, and rsp_e*rsp_d ≡ 1 mod 3432.
- Bad arguments:
  - Stimulus: req p=53, q=53; then p=1, q=7.
  - Required: rsp_err=1 two cycles after accept, with no start pulses.
- Timeout:
  - Stimulus: nominal request with fin1 held at 0 forever.
  - Required: rsp_err=2 after exactly TIMEOUT cycles in S2_WAIT.
  - Required: rsp_n=3551 retained and rsp_c=0.
- M>=n:
  - Stimulus: M=4000, p=67, q=53.
  - Required: rsp_err=3 right after finish, with no start1 or start2 pulse.
- Backpressure and stale flags:
  - Stimulus: hold rsp_ready=0 for 20 cycles; keep finish stuck at 1 from the previous run; then present back-to-back requests.
  - Required: rsp fields stable and req_ready=0 throughout the stall.
  - Required: blanking prevents a 0-cycle false completion.
  - Required: the second request is accepted in the first IDLE cycle after the response handshake.
- Reset mid-run:
  - Stimulus: assert rst during S1_WAIT.
  - Required: all outputs 0 asynchronously, with no rsp_valid.
  - Required: a subsequent request completes normally.
